// File: rtl/unary_stream_encoder_if.sv
// -----------------------------------------------------------------------------
// unary_stream_encoder_if
//
// Purpose:
//    Bundles the load handshake, the stall request and the unary operand
//    stream of the unary_stream_encoder into one interface so the encoder, its
//    upstream loader and its downstream unary arithmetic consumer can share a
//    single connection.
//
// Parameters:
//    INPUT_WIDTH  - stream length N in qualified bits.
//    COUNT_WIDTH  - width of value / ones_sent / bits_sent. Must match the
//                   encoder instance this interface is bound to.
//
// Signals:
//    value      - number of ones to encode (clamped to N inside the encoder).
//    mode       - 0 = evenly spread ones, 1 = thermometer (ones first).
//    load       - start request, taken only while in_ready is high.
//    hold       - stall request; freezes the stream while high.
//    in_ready   - encoder idle and able to accept load.
//    a          - stream bit, meaningful only while ready is high.
//    ready      - stream qualifier for the downstream unit.
//    done       - one-cycle pulse after the last bit of a stream.
//    ones_sent  - ones emitted so far in the current stream.
//    bits_sent  - bits emitted so far in the current stream.
//
// Modports:
//    master  - upstream side: drives value/mode/load/hold, observes the rest.
//    slave   - the encoder itself.
//    monitor - passive observer (e.g. downstream consumer or checker).
// -----------------------------------------------------------------------------
interface unary_stream_encoder_if #(
   parameter int INPUT_WIDTH = 32,
   parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
);

   logic [COUNT_WIDTH-1:0] value;
   logic                   mode;
   logic                   load;
   logic                   hold;
   logic                   in_ready;
   logic                   a;
   logic                   ready;
   logic                   done;
   logic [COUNT_WIDTH-1:0] ones_sent;
   logic [COUNT_WIDTH-1:0] bits_sent;

   modport master (
      output value,
      output mode,
      output load,
      output hold,
      input  in_ready,
      input  a,
      input  ready,
      input  done,
      input  ones_sent,
      input  bits_sent
   );

   modport slave (
      input  value,
      input  mode,
      input  load,
      input  hold,
      output in_ready,
      output a,
      output ready,
      output done,
      output ones_sent,
      output bits_sent
   );

   modport monitor (
      input value,
      input mode,
      input load,
      input hold,
      input in_ready,
      input a,
      input ready,
      input done,
      input ones_sent,
      input bits_sent
   );

endinterface : unary_stream_encoder_if

// File: rtl/unary_stream_encoder.sv
// -----------------------------------------------------------------------------
// unary_stream_encoder
//
// Purpose:
//    Binary-to-unary bitstream transmitter. A binary count v (clamped to N) is
//    accepted through a load handshake and turned into exactly N qualified
//    bits (a qualified by ready) that contain exactly v ones. The ones are
//    either spread evenly with a Bresenham accumulator or packed first as a
//    thermometer code. Evenly spread streams let downstream bound-tracking
//    unary units converge on good early estimates.
//
// Parameters:
//    INPUT_WIDTH  - stream length N (default 32).
//    COUNT_WIDTH  - width of counts and of value (default clog2(N+1)); must
//                   match the parameter of the connected interface.
//
// Ports:
//    clk    - single clock, all state changes on the rising edge.
//    reset  - synchronous, active-low; wins over load and hold.
//    bus    - unary_stream_encoder_if.slave:
//               inputs  value, mode, load, hold
//               outputs in_ready (combinational, high in IDLE),
//                       a, ready, done, ones_sent, bits_sent (registered)
//
// Timing (no stalls), load accepted at edge t:
//    ready high after edges t+1 .. t+N, done high after edge t+N+1, in which
//    cycle in_ready is already high again. Each stalled edge adds one cycle.
// -----------------------------------------------------------------------------
module unary_stream_encoder #(
   parameter int INPUT_WIDTH = 32,
   parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   unary_stream_encoder_if.slave  bus
);

   // --------------------------------------------------------------------------
   // Constants
   // --------------------------------------------------------------------------
   // N in the count width (used for clamping and the thermometer compare) and
   // in the accumulator width (one bit wider, used by the Bresenham step).
   localparam logic [COUNT_WIDTH-1:0] N_CNT    = COUNT_WIDTH'(INPUT_WIDTH);
   localparam logic [COUNT_WIDTH:0]   N_ACC    = (COUNT_WIDTH + 1)'(INPUT_WIDTH);
   localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(INPUT_WIDTH - 1);
   // Starting the accumulator at N/2 rounds the spread to the nearest slot,
   // so after k bits ones_sent = floor((floor(N/2) + k*v) / N).
   localparam logic [COUNT_WIDTH:0]   ACC_INIT = (COUNT_WIDTH + 1)'(INPUT_WIDTH / 2);
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

   // --------------------------------------------------------------------------
   // State encoding
   // --------------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // --------------------------------------------------------------------------
   // Registers
   // --------------------------------------------------------------------------
   state_t                 r_state;
   logic [COUNT_WIDTH-1:0] r_v;          // latched, clamped count of ones
   logic                   r_mode;       // latched spread mode
   logic [COUNT_WIDTH:0]   r_acc;        // Bresenham error accumulator
   logic [COUNT_WIDTH-1:0] r_bits_sent;
   logic [COUNT_WIDTH-1:0] r_ones_sent;
   logic                   r_a;
   logic                   r_ready;
   logic                   r_done;

   // --------------------------------------------------------------------------
   // Next-state wires
   // --------------------------------------------------------------------------
   state_t                 w_state_next;
   logic [COUNT_WIDTH-1:0] w_v_next;
   logic                   w_mode_next;
   logic [COUNT_WIDTH:0]   w_acc_next;
   logic [COUNT_WIDTH-1:0] w_bits_sent_next;
   logic [COUNT_WIDTH-1:0] w_ones_sent_next;
   logic                   w_a_next;
   logic                   w_ready_next;
   logic                   w_done_next;

   // --------------------------------------------------------------------------
   // Datapath helpers
   // --------------------------------------------------------------------------
   logic [COUNT_WIDTH-1:0] w_v_clamped;
   logic [COUNT_WIDTH:0]   w_sum;
   logic                   w_even_bit;
   logic [COUNT_WIDTH:0]   w_acc_step;
   logic                   w_therm_bit;
   logic                   w_bit;
   logic                   w_last_bit;

   // Values above N would otherwise overflow the one-per-slot budget; clamp
   // them so the stream saturates to all ones.
   assign w_v_clamped = (bus.value > N_CNT) ? N_CNT : bus.value;

   // Even mode: the accumulator stays below N, v is at most N, so the sum is
   // at most 2N-1 and always fits in COUNT_WIDTH+1 bits.
   assign w_sum      = r_acc + {1'b0, r_v};
   assign w_even_bit = (w_sum >= N_ACC);
   assign w_acc_step = w_even_bit ? (w_sum - N_ACC) : w_sum;

   // Thermometer mode: the first v bits are ones.
   assign w_therm_bit = (r_bits_sent < r_v);

   assign w_bit      = r_mode ? w_therm_bit : w_even_bit;
   assign w_last_bit = (r_bits_sent == LAST_IDX);

   // --------------------------------------------------------------------------
   // Next-state / output logic
   // --------------------------------------------------------------------------
   always_comb begin
      // Hold everything by default; the stream outputs fall to 0 unless a bit
      // is emitted this edge, and done is only ever a single-cycle pulse.
      w_state_next     = r_state;
      w_v_next         = r_v;
      w_mode_next      = r_mode;
      w_acc_next       = r_acc;
      w_bits_sent_next = r_bits_sent;
      w_ones_sent_next = r_ones_sent;
      w_a_next         = 1'b0;
      w_ready_next     = 1'b0;
      w_done_next      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            // hold has no meaning before a stream exists.
            if (bus.load) begin
               w_v_next         = w_v_clamped;
               w_mode_next      = bus.mode;
               w_acc_next       = ACC_INIT;
               w_bits_sent_next = '0;
               w_ones_sent_next = '0;
               w_state_next     = ST_STREAM;
            end
         end

         ST_STREAM: begin
            // A stalled edge emits nothing and freezes the counters, the
            // accumulator and the state, so a stall on the last bit also
            // postpones the move to DONE. load is ignored throughout.
            if (!bus.hold) begin
               w_a_next         = w_bit;
               w_ready_next     = 1'b1;
               w_bits_sent_next = r_bits_sent + CNT_ONE;
               w_ones_sent_next = r_ones_sent + {{(COUNT_WIDTH - 1){1'b0}}, w_bit};
               if (!r_mode) begin
                  w_acc_next = w_acc_step;
               end
               if (w_last_bit) begin
                  w_state_next = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            // Counters keep their final values for inspection until the
            // next load clears them.
            w_done_next  = 1'b1;
            w_state_next = ST_IDLE;
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         // A stream cut short by reset is simply abandoned: no done pulse.
         r_state     <= ST_IDLE;
         r_v         <= '0;
         r_mode      <= 1'b0;
         r_acc       <= '0;
         r_bits_sent <= '0;
         r_ones_sent <= '0;
         r_a         <= 1'b0;
         r_ready     <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_v         <= w_v_next;
         r_mode      <= w_mode_next;
         r_acc       <= w_acc_next;
         r_bits_sent <= w_bits_sent_next;
         r_ones_sent <= w_ones_sent_next;
         r_a         <= w_a_next;
         r_ready     <= w_ready_next;
         r_done      <= w_done_next;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   // in_ready is decoded straight from the state so a load can be accepted in
   // the same cycle that done is high, giving back-to-back streams.
   assign bus.in_ready  = (r_state == ST_IDLE);
   assign bus.a         = r_a;
   assign bus.ready     = r_ready;
   assign bus.done      = r_done;
   assign bus.ones_sent = r_ones_sent;
   assign bus.bits_sent = r_bits_sent;

endmodule : unary_stream_encoder

// File: tb/tb_unary_stream_encoder.sv
// -----------------------------------------------------------------------------
// tb_unary_stream_encoder
//
// Drives unary_stream_encoder through its interface and compares every cycle
// with a reference model expressed directly in terms of ones-per-prefix:
//    even mode:        ones(k) = floor((floor(N/2) + k*v) / N)
//    thermometer mode: ones(k) = min(k, v)
// The expected bit at index k is ones(k+1) - ones(k).
// -----------------------------------------------------------------------------
module tb_unary_stream_encoder;

   localparam int N  = 32;
   localparam int CW = $clog2(N + 1);

   logic clk   = 1'b0;
   logic reset = 1'b0;

   unary_stream_encoder_if #(.INPUT_WIDTH(N), .COUNT_WIDTH(CW)) bus ();

   unary_stream_encoder #(
      .INPUT_WIDTH (N),
      .COUNT_WIDTH (CW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // ---------------------------------------------------------------- helpers
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_ones(input int v, input bit md, input int k);
      if (md) return (k < v) ? k : v;
      return ((N / 2) + k * v) / N;
   endfunction

   function automatic int exp_bit(input int v, input bit md, input int k);
      return exp_ones(v, md, k + 1) - exp_ones(v, md, k);
   endfunction

   // Load one stream and follow it to its done cycle. stall_mask bit k stalls
   // the edge that would emit bit k (once). disturb pulses load and flips mode
   // mid-stream; neither may affect the stream. Returns in the done cycle.
   task automatic run_stream(input int val, input bit md,
                             input logic [63:0] stall_mask, input bit disturb);
      int v;
      int k;
      int cycles;
      int q_bits;
      int q_ones;
      int n_stalls;
      bit hh;
      logic [63:0] stalled;
      v        = (val > N) ? N : val;
      k        = 0;
      cycles   = 0;
      q_bits   = 0;
      q_ones   = 0;
      stalled  = '0;
      n_stalls = $countones(stall_mask[N-1:0]);

      check("in_ready_before_load", 32'(bus.in_ready), 32'd1);
      bus.value = CW'(val);
      bus.mode  = md;
      bus.load  = 1'b1;
      bus.hold  = 1'b0;
      tick();
      bus.load = 1'b0;
      check("ready_after_load", 32'(bus.ready), 32'd0);
      check("done_after_load", 32'(bus.done), 32'd0);
      check("in_ready_busy", 32'(bus.in_ready), 32'd0);
      check("bits_cleared", 32'(bus.bits_sent), 32'd0);
      check("ones_cleared", 32'(bus.ones_sent), 32'd0);

      while (k < N && cycles < 3 * N) begin
         cycles++;
         hh = stall_mask[k] && !stalled[k];
         if (hh) stalled[k] = 1'b1;
         bus.hold = hh;
         bus.load = disturb && (k == 10);
         if (disturb && k == 10) bus.value = CW'((val + 7) % 41);
         if (disturb && k >= 10) bus.mode = ~md;
         tick();
         if (hh) begin
            check("ready_stalled", 32'(bus.ready), 32'd0);
            check("a_stalled", 32'(bus.a), 32'd0);
            check("bits_frozen", 32'(bus.bits_sent), 32'(k));
            check("ones_frozen", 32'(bus.ones_sent), 32'(exp_ones(v, md, k)));
         end else begin
            check("ready_stream", 32'(bus.ready), 32'd1);
            if (bus.ready !== 1'b1) break;
            check("a_bit", 32'(bus.a), 32'(exp_bit(v, md, k)));
            k++;
            q_bits++;
            q_ones += int'(bus.a);
            check("bits_sent", 32'(bus.bits_sent), 32'(k));
            check("ones_sent", 32'(bus.ones_sent), 32'(exp_ones(v, md, k)));
         end
         check("done_in_stream", 32'(bus.done), 32'd0);
      end
      bus.hold = 1'b0;
      bus.load = 1'b0;
      bus.mode = md;

      check("stream_cycles", 32'(cycles), 32'(N + n_stalls));
      check("qualified_bits", 32'(q_bits), 32'(N));
      check("qualified_ones", 32'(q_ones), 32'(v));
      tick();
      check("done_pulse", 32'(bus.done), 32'd1);
      check("ready_in_done", 32'(bus.ready), 32'd0);
      check("a_in_done", 32'(bus.a), 32'd0);
      check("in_ready_in_done", 32'(bus.in_ready), 32'd1);
      check("final_bits", 32'(bus.bits_sent), 32'(N));
      check("final_ones", 32'(bus.ones_sent), 32'(v));
      $display("stream value=%0d mode=%0d stalls=%0d disturb=%0d ones=%0d cycles=%0d",
               val, md, n_stalls, disturb, q_ones, cycles);
   endtask

   // ----------------------------------------------------------- main sequence
   initial begin
      logic [63:0] mask;
      int          rv;
      bit          rm;
      bit          rd;

      bus.value = '0;
      bus.mode  = 1'b0;
      bus.load  = 1'b0;
      bus.hold  = 1'b0;

      // Reset held for three edges, with load requested to show priority.
      reset    = 1'b0;
      bus.load = 1'b1;
      repeat (3) tick();
      bus.load = 1'b0;
      check("rst_a", 32'(bus.a), 32'd0);
      check("rst_ready", 32'(bus.ready), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_ones", 32'(bus.ones_sent), 32'd0);
      check("rst_bits", 32'(bus.bits_sent), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      reset = 1'b1;
      tick();
      check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("post_rst_ready", 32'(bus.ready), 32'd0);
      $display("reset released");

      // Directed streams.
      run_stream(8, 1'b0, 64'd0, 1'b0);
      tick();
      check("done_falls", 32'(bus.done), 32'd0);
      run_stream(16, 1'b0, 64'd0, 1'b0);
      tick();
      run_stream(0, 1'b0, 64'd0, 1'b0);
      tick();
      run_stream(40, 1'b0, 64'd0, 1'b0);
      tick();
      run_stream(5, 1'b1, 64'd0, 1'b1);
      tick();

      // Stalls on bits 3, 4 and the last bit, plus a mid-stream load.
      mask = '0;
      mask[3] = 1'b1;
      mask[4] = 1'b1;
      mask[N-1] = 1'b1;
      run_stream(8, 1'b0, mask, 1'b1);
      // Back-to-back: load straight from the done cycle.
      run_stream(24, 1'b0, 64'd0, 1'b0);
      tick();
      check("b2b_done_falls", 32'(bus.done), 32'd0);

      // Reset in the middle of a stream.
      bus.value = CW'(20);
      bus.mode  = 1'b0;
      bus.load  = 1'b1;
      tick();
      bus.load = 1'b0;
      repeat (10) tick();
      check("pre_rst_bits", 32'(bus.bits_sent), 32'd10);
      reset = 1'b0;
      bus.hold = 1'b1;
      tick();
      bus.hold = 1'b0;
      check("midrst_ready", 32'(bus.ready), 32'd0);
      check("midrst_a", 32'(bus.a), 32'd0);
      check("midrst_bits", 32'(bus.bits_sent), 32'd0);
      check("midrst_ones", 32'(bus.ones_sent), 32'd0);
      check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      check("midrst_done", 32'(bus.done), 32'd0);
      reset = 1'b1;
      repeat (2) begin
         tick();
         check("midrst_no_done", 32'(bus.done), 32'd0);
         check("midrst_idle", 32'(bus.in_ready), 32'd1);
      end
      $display("mid-stream reset done");
      run_stream(13, 1'b0, 64'd0, 1'b0);
      tick();

      // Randomized streams.
      for (int s = 0; s < 8; s++) begin
         rv   = int'($urandom_range(0, 40));
         rm   = 1'($urandom_range(0, 1));
         rd   = 1'($urandom_range(0, 1));
         mask = '0;
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 9) == 0) mask[b] = 1'b1;
         end
         run_stream(rv, rm, mask, rd);
         if ($urandom_range(0, 1) == 1) begin
            tick();
            check("rand_done_falls", 32'(bus.done), 32'd0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global time bound so the bench always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
      $fatal(1, "time limit");
   end

endmodule : tb_unary_stream_encoder

// File: doc/unary_stream_encoder.md
# unary_stream_encoder

Binary-to-unary bitstream transmitter that produces the `a`/`ready` operand stream consumed by the unary arithmetic units (e.g. the unary square-root block). It accepts a binary count through a load handshake and emits exactly `INPUT_WIDTH` qualified bits containing exactly that many ones. Ones are either evenly spread (Bresenham) or packed first (thermometer). Evenly spread streams give downstream bound-tracking units accurate early estimates.

## Interface

**Parameters**
- `INPUT_WIDTH`, default 32: stream length N in qualified bits.
- `COUNT_WIDTH`, default `$clog2(INPUT_WIDTH+1)`: width of counts and of `value`.

**Ports**
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-low. Sampled on the `clk` rising edge only.
- `value`, input, COUNT_WIDTH: number of ones to encode. Values above N are clamped to N at load.
- `mode`, input, 1: 0 = evenly spread, 1 = thermometer. Latched at load.
- `load`, input, 1: request to start a stream. Accepted only when `in_ready`=1.
- `hold`, input, 1: stall request. While high in STREAM, no bit is emitted and all state is frozen.
- `in_ready`, output, 1: combinational; high exactly when the state is IDLE.
- `a`, output, 1: registered stream bit. Valid only when `ready`=1, otherwise driven 0.
- `ready`, output, 1: registered qualifier; connects to the downstream `ready` input.
- `done`, output, 1: registered one-cycle pulse after the last bit.
- `ones_sent`, output, COUNT_WIDTH: registered count of ones emitted in the current stream.
- `bits_sent`, output, COUNT_WIDTH: registered count of bits emitted in the current stream.

## Operation

**States:** IDLE, STREAM, DONE. The state register is 2 bits.

**IDLE**
- If `load`=1 at an edge:
  - latch `v = min(value, N)` and `mode`;
  - set `acc = N>>1`, `bits_sent = 0`, `ones_sent = 0`;
  - go to STREAM.
- `hold` is ignored in IDLE.

**STREAM**, at each edge with `hold`=0:
- Compute the next bit:
  - Even mode: `s = acc + v`. If `s >= N` then bit = 1 and `acc <= s - N`; otherwise bit = 0 and `acc <= s`. `acc` is COUNT_WIDTH+1 bits wide; `s` never exceeds 2N-1.
  - Thermometer mode: bit = (`bits_sent < v`). `acc` is unused.
- Register the bit: `a <= bit`, `ready <= 1`, `bits_sent++`, `ones_sent += bit`.
- When `bits_sent == N-1` before the increment (that is, on the last bit), go to DONE.

**STREAM**, at each edge with `hold`=1:
- `ready <= 0`, `a <= 0`.
- `acc`, `bits_sent`, `ones_sent` and the state are unchanged.

**DONE**
- The next edge sets `ready <= 0`, `a <= 0`, `done <= 1`, and goes to IDLE.
- `done` returns to 0 at the following edge.
- `bits_sent` and `ones_sent` hold their final values until the next load.

**Guarantees**
- Every stream has exactly N qualified bits and exactly `v` ones, in both modes.
- In even mode, after k qualified bits, `ones_sent = floor((floor(N/2) + k*v) / N)`.

**Boundary conditions**
- `load` while not IDLE: ignored. The in-flight stream is unaffected.
- `value` = 0: N zeros. `value` ≥ N: N ones.
- `hold` asserted on the edge that would emit the last bit: that bit is deferred, and the transition to DONE is deferred with it.
- `reset`=0 at any edge, including mid-stream:
  - state goes to IDLE;
  - `a`, `ready`, `done`, `ones_sent`, `bits_sent`, `acc` and the latched `v`/`mode` all go to 0;
  - a partial stream is abandoned with no `done` pulse.
- `reset` has priority over `load` and `hold`.

## Timing

- **Reset values:** `a`=0, `ready`=0, `done`=0, `ones_sent`=0, `bits_sent`=0, `in_ready`=1 (IDLE).
- **First bit:** with load accepted at edge t and no hold, the first `ready`=1 is visible after edge t+1.
- **Stream duration:** `ready` stays high for N consecutive cycles, edges t+1..t+N.
- **Completion:** `done`=1 after edge t+N+1, and `in_ready`=1 in that same cycle.
- **Stall cost:** each stalled edge adds exactly one cycle to the stream.
- **Back-to-back:** a load accepted in the `done` cycle gives a minimum gap of 2 cycles with `ready`=0 between streams.

## Test plan

- **Reset:** hold `reset`=0 for 3 cycles, then release → all outputs at their reset values and `in_ready`=1. Then load `value`=8 with `mode`=0 → `a` = 0,1,0,0,0,1,… with ones at bit indices 1,5,…,29; final `ones_sent`=8, `bits_sent`=32; `done` pulses once, 33 cycles after the load edge.
- **Even mode, extremes:** `value`=16 → strictly alternating 1,0 starting with 1. `value`=0 → 32 zeros. `value`=40 → 32 ones with `ones_sent`=32.
- **Thermometer mode:** `value`=5, `mode`=1 → 5 ones then 27 zeros. Change `mode` mid-stream → no effect on the stream.
- **Stall and ignored load:** assert `hold` on bits 3, 4 and the last bit → `ready`=0 on those edges, pattern identical to the unstalled stream, `done` delayed by 3 cycles. Pulse `load` mid-stream → ignored.
- **Reset mid-stream:** assert `reset`=0 at bit 10 → next cycle `ready`=0, counters 0, `in_ready`=1, no `done` pulse. A new load then produces a fresh full stream.
- **Downstream check:** drive `load` in the `done` cycle with `value`=24 → 2-cycle gap between streams. Connect to the unary root unit and confirm the downstream count of `ready` pulses is 32 per stream.
